clock_div_multi: RTL and testbench
==================================

Name: clock_div_multi

Overview:
N-channel programmable clock divider generating f_in / div per channel for any integer div >= 2, not only powers of two.
- Divisor changes are shadowed and applied only at period boundaries, so outputs never glitch.
- Each channel has run/stop control with clean completion of the current period.
- A common sync input phase-aligns all channels.
- Sits between the board reference clock and the shift-register / test-pattern engines that need several slow clocks or clock-enable strobes.

Parameters:
- N_CH, 4, number of independent divider channels.
- DIV_WIDTH, 16, width of each divisor value; max divide = 2**DIV_WIDTH-1.

Ports:
- clk_in  input  1  reference clock; all logic on posedge (plus negedge if optional feature on).
- rst  input  1  asynchronous, active-high reset.
- div_val  input  N_CH*DIV_WIDTH  per-channel divisor; channel i at bits [i*DIV_WIDTH +: DIV_WIDTH].
- div_load  input  N_CH  per-channel strobe; captures div_val slice into shadow register.
- ch_en  input  N_CH  per-channel run request (level).
- sync  input  1  single-cycle pulse; restarts all running channels at phase 0.
- clk_out  output  N_CH  divided clocks.
- tick  output  N_CH  one-clk_in-cycle strobe at last cycle of each period (clock-enable use).
- busy  output  N_CH  channel is running (includes stopping period).

Behaviour:
- Reset values:
  - all counters 0; all outputs 0.
  - shadow and active divisors = 2.
  - all channels in IDLE.
- Divisor clamp: any loaded value < 2 is stored as 2.
- Per channel registers:
  - cnt[DIV_WIDTH], shadow div_sh, active div_act.
  - H = (div_act+1)>>1, computed DIV_WIDTH+1 wide with no overflow.
- div_load[i] high at an edge: div_sh <= clamp(div slice).
  - div_act <= div_sh when the channel enters RUN from IDLE, and at every wrap (cnt == div_act-1).
  - A load on the same edge as a wrap is applied at the following wrap, not at this one.
- States per channel: IDLE, RUN, STOP.
  - IDLE: cnt=0, clk_out=0, tick=0, busy=0. ch_en=1 sampled -> RUN; next edge cnt=0, clk_out=1, busy=1 (1-cycle latency).
  - RUN: cnt increments and wraps div_act-1 -> 0. clk_out registered = (cnt_next < H). tick registered = (cnt_next == div_act-1). ch_en=0 sampled -> STOP.
  - STOP: keeps counting; at wrap -> IDLE (clk_out 0, busy 0). ch_en=1 again while in STOP -> back to RUN with no interruption.
- Period and duty:
  - Period = div_act cycles.
  - High time = ceil(div_act/2) cycles; low time = floor(div_act/2) cycles.
  - div=2 gives f_in/2 square wave with tick every 2nd cycle.
- sync:
  - Every channel in RUN/STOP reloads cnt=0, clk_out=1 and applies div_sh at that edge.
  - sync takes priority over wrap and over ch_en deassert on the same edge; STOP channels then continue STOP from phase 0.
  - IDLE channels are unaffected.
- Simultaneous events:
  - ch_en rise and div_load on the same edge from IDLE: the new value is used (shadow written first, bypassed into div_act).
- rst mid-operation: immediate return to reset values, no completion of the current period.

Optional Feature:
CLK_DIV_ODD50_EN
- Defined:
  - Each channel adds a negedge flop capturing the posedge clk_out (A) as B.
  - For odd div_act the output is A & B, giving high time exactly div/2 cycles (50% duty).
  - For even div the output is A only.
  - tick is unchanged.
- Undefined:
  - No negedge logic; odd divisors have high time (div+1)/2 cycles.
  - Same port list in both builds.

Test Plan:
1. Reset, div_load ch0 with 5, ch_en[0]=1 -> clk_out[0] period 5 cycles, high 3/low 2 (high 2.5 with ODD50_EN); tick[0] every 5th cycle coincident with cnt 4; busy[0]=1 one cycle after enable.
2. Ch1 running div=4; load 10 mid-period -> current period completes as 4, next periods 10; no clk_out pulse shorter than 2 cycles.
3. div_load value 0 and 1 -> behaves as div=2: clk_out toggles every cycle, tick every 2nd cycle.
4. Ch2 div=6 running, drop ch_en at cnt 1 -> remaining 4 cycles of period complete, then clk_out=0, busy=0; re-enable -> restarts with clk_out=1 next cycle.
5. Ch0 div=3, ch1 div=7 free-running, pulse sync -> both show cnt=0/clk_out=1 on the next edge, rising edges aligned; IDLE ch3 stays 0.
6. Assert rst mid-period with all channels running -> all outputs 0 immediately; after release, channels IDLE until ch_en; active divisors back to 2.

Source files
------------

// File: rtl/clock_div_multi.sv
// clock_div_multi: N-channel programmable integer clock divider.
// Each channel divides clk_in by any div >= 2, with shadowed divisor updates at
// period boundaries, run/stop control with clean period completion and a common
// sync input that phase-aligns all running channels.
// Optional build macro: CLK_DIV_ODD50_EN (negedge retiming for 50% duty on odd divisors).
module clock_div_multi #(
    parameter int N_CH      = 4,
    parameter int DIV_WIDTH = 16
) (
    input  logic                      clk_in,
    input  logic                      rst,
    input  logic [N_CH*DIV_WIDTH-1:0] div_val,
    input  logic [N_CH-1:0]           div_load,
    input  logic [N_CH-1:0]           ch_en,
    input  logic                      sync,
    output logic [N_CH-1:0]           clk_out,
    output logic [N_CH-1:0]           tick,
    output logic [N_CH-1:0]           busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } ch_state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ch_state_t            state;
        ch_state_t            state_nxt;
        logic [DIV_WIDTH-1:0] cnt;
        logic [DIV_WIDTH-1:0] cnt_nxt;
        logic [DIV_WIDTH-1:0] cnt_inc;
        logic [DIV_WIDTH-1:0] div_sh;
        logic [DIV_WIDTH-1:0] div_sh_nxt;
        logic [DIV_WIDTH-1:0] div_act;
        logic [DIV_WIDTH-1:0] div_act_nxt;
        logic [DIV_WIDTH-1:0] div_last;
        logic [DIV_WIDTH-1:0] load_val;
        logic [DIV_WIDTH:0]   half;
        logic                 clk_a;
        logic                 clk_a_nxt;
        logic                 tick_r;
        logic                 tick_nxt;
        logic                 wrap;

        // Loaded divisors below 2 are forced to 2 so a period is never shorter than two cycles.
        assign load_val = (div_val[i*DIV_WIDTH +: DIV_WIDTH] < DIV_MIN) ? DIV_MIN
                                                                        : div_val[i*DIV_WIDTH +: DIV_WIDTH];
        assign div_last = div_act - 1'b1;
        assign cnt_inc  = cnt + 1'b1;
        assign wrap     = (cnt == div_last);
        // High-phase length, one bit wider so the +1 cannot overflow at the max divisor.
        assign half     = ({1'b0, div_act} + 1'b1) >> 1;

        // Next-state logic: run/stop sequencing, counter wrap, sync realignment and divisor shadowing.
        always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt;
            div_sh_nxt  = div_load[i] ? load_val : div_sh;
            div_act_nxt = div_act;
            clk_a_nxt   = clk_a;
            tick_nxt    = 1'b0;
            case (state)
                IDLE: begin
                    cnt_nxt   = '0;
                    clk_a_nxt = 1'b0;
                    if (ch_en[i]) begin
                        state_nxt   = RUN;
                        div_act_nxt = div_load[i] ? load_val : div_sh;
                        clk_a_nxt   = 1'b1;
                    end
                end
                RUN, STOP: begin
                    if (sync) begin
                        cnt_nxt     = '0;
                        div_act_nxt = div_sh;
                        clk_a_nxt   = 1'b1;
                    end else begin
                        if (ch_en[i]) begin
                            state_nxt = RUN;
                        end else if ((state == RUN) || !wrap) begin
                            state_nxt = STOP;
                        end else begin
                            state_nxt = IDLE;
                        end
                        if (wrap) begin
                            cnt_nxt     = '0;
                            div_act_nxt = div_sh;
                            clk_a_nxt   = (state_nxt != IDLE);
                        end else begin
                            cnt_nxt   = cnt_inc;
                            clk_a_nxt = ({1'b0, cnt_inc} < half);
                            tick_nxt  = (cnt_inc == div_last);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        // Channel state, counter, divisor registers and registered outputs.
        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                state   <= IDLE;
                cnt     <= '0;
                div_sh  <= DIV_MIN;
                div_act <= DIV_MIN;
                clk_a   <= 1'b0;
                tick_r  <= 1'b0;
            end else begin
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                div_sh  <= div_sh_nxt;
                div_act <= div_act_nxt;
                clk_a   <= clk_a_nxt;
                tick_r  <= tick_nxt;
            end
        end

`ifdef CLK_DIV_ODD50_EN
        logic clk_b;

        // Half-cycle delayed copy of the divided clock, used to trim odd high phases to div/2.
        always_ff @(negedge clk_in or posedge rst) begin
            if (rst) begin
                clk_b <= 1'b0;
            end else begin
                clk_b <= clk_a;
            end
        end

        assign clk_out[i] = div_act[0] ? (clk_a & clk_b) : clk_a;
`else
        assign clk_out[i] = clk_a;
`endif
        assign tick[i] = tick_r;
        assign busy[i] = (state != IDLE);
    end

endmodule

// File: tb/tb_clock_div_multi.sv
// tb_clock_div_multi: directed scoreboard bench for clock_div_multi (default build).
// Stimulus pushes the expected per-cycle outputs; a monitor pops and compares after each edge.
module tb_clock_div_multi;

    localparam int N_CH      = 4;
    localparam int DIV_WIDTH = 16;

    logic                      clk_in = 1'b0;
    logic                      rst;
    logic [N_CH*DIV_WIDTH-1:0] div_val;
    logic [N_CH-1:0]           div_load;
    logic [N_CH-1:0]           ch_en;
    logic                      sync;
    logic [N_CH-1:0]           clk_out;
    logic [N_CH-1:0]           tick;
    logic [N_CH-1:0]           busy;

    logic                      nxt_rst;
    logic [N_CH*DIV_WIDTH-1:0] nxt_div;
    logic [N_CH-1:0]           nxt_load;
    logic [N_CH-1:0]           nxt_en;
    logic                      nxt_sync;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] eclk;
        logic [3:0] etck;
        logic [3:0] ebsy;
        int         test;
        int         step;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cur_test = 0;
    int   cur_step = 0;

    always #5 clk_in = ~clk_in;

    clock_div_multi #(
        .N_CH      (N_CH),
        .DIV_WIDTH (DIV_WIDTH)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .div_val  (div_val),
        .div_load (div_load),
        .ch_en    (ch_en),
        .sync     (sync),
        .clk_out  (clk_out),
        .tick     (tick),
        .busy     (busy)
    );

    function automatic logic [3:0] chMask(input int ch);
        return 4'b0001 << ch;
    endfunction

    // Drive the staged inputs at a falling edge and queue what the next rising edge must produce.
    task automatic applyStimulus(input logic [3:0] mask, input logic [3:0] eclk,
                                 input logic [3:0] etck, input logic [3:0] ebsy);
        exp_t e;
        @(negedge clk_in);
        rst      = nxt_rst;
        div_val  = nxt_div;
        div_load = nxt_load;
        ch_en    = nxt_en;
        sync     = nxt_sync;
        e.mask   = mask;
        e.eclk   = eclk;
        e.etck   = etck;
        e.ebsy   = ebsy;
        e.test   = cur_test;
        e.step   = cur_step;
        sb.push_back(e);
        cur_step = cur_step + 1;
        nxt_load = '0;
        nxt_sync = 1'b0;
    endtask

    task automatic checkOutput(input exp_t e);
        if (e.mask != 4'b0000) begin
            checks = checks + 1;
            if (((clk_out & e.mask) !== (e.eclk & e.mask)) ||
                ((tick & e.mask) !== (e.etck & e.mask)) ||
                ((busy & e.mask) !== (e.ebsy & e.mask))) begin
                errors = errors + 1;
                $display("[TB] FAIL test%0d step%0d: clk_out=%b tick=%b busy=%b, required clk_out=%b tick=%b busy=%b (mask %b)",
                         e.test, e.step, clk_out, tick, busy, e.eclk, e.etck, e.ebsy, e.mask);
            end
        end
    endtask

    task automatic setDiv(input int ch, input logic [DIV_WIDTH-1:0] val);
        nxt_div[ch*DIV_WIDTH +: DIV_WIDTH] = val;
        nxt_load[ch] = 1'b1;
    endtask

    task automatic startTest(input int t);
        cur_test = t;
        cur_step = 0;
        $display("[TB] test %0d", t);
    endtask

    task automatic resetPulse();
        nxt_en  = '0;
        nxt_rst = 1'b1;
        applyStimulus(4'hF, 4'h0, 4'h0, 4'h0);
        nxt_rst = 1'b0;
        applyStimulus(4'hF, 4'h0, 4'h0, 4'h0);
    endtask

    // Run a single-channel pattern; bit k of each pattern is the required value k cycles in.
    task automatic stepCh(input int ch, input logic c, input logic t, input logic b);
        logic [3:0] m;
        m = chMask(ch);
        applyStimulus(m, c ? m : 4'h0, t ? m : 4'h0, b ? m : 4'h0);
    endtask

    // Monitor: after every rising edge, pop one expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        logic [31:0] pc;
        logic [31:0] pt;
        logic [31:0] pb;
        logic [3:0]  clk5[10];
        logic [3:0]  tck5[10];

        rst      = 1'b1;
        div_val  = '0;
        div_load = '0;
        ch_en    = '0;
        sync     = 1'b0;
        nxt_rst  = 1'b1;
        nxt_div  = '0;
        nxt_load = '0;
        nxt_en   = '0;
        nxt_sync = 1'b0;

        // Test 1: div 5 on ch0, high 3 / low 2, tick on cnt 4, busy one cycle after enable.
        startTest(1);
        resetPulse();
        setDiv(0, 16'd5);
        applyStimulus(4'b0001, 4'h0, 4'h0, 4'h0);
        nxt_en[0] = 1'b1;
        pc = 32'd231;
        pt = 32'd528;
        for (int k = 0; k < 10; k++) stepCh(0, pc[k], pt[k], 1'b1);
        nxt_en = '0;
        for (int k = 0; k < 8; k++) applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);

        // Test 2: ch1 starts at div 4 (load with enable), load 10 mid-period.
        startTest(2);
        resetPulse();
        setDiv(1, 16'd4);
        nxt_en[1] = 1'b1;
        pc = 32'd16883;
        pt = 32'd8200;
        for (int k = 0; k < 15; k++) begin
            if (k == 2) setDiv(1, 16'd10);
            stepCh(1, pc[k], pt[k], 1'b1);
        end

        // Test 3: loads of 0 and 1 clamp to 2; load on a wrap edge waits one more period.
        startTest(3);
        resetPulse();
        setDiv(3, 16'd0);
        nxt_en[3] = 1'b1;
        pc = 32'd10709;
        pt = 32'd5162;
        for (int k = 0; k < 14; k++) begin
            if (k == 4) setDiv(3, 16'd5);
            if (k == 9) setDiv(3, 16'd1);
            stepCh(3, pc[k], pt[k], 1'b1);
        end

        // Test 4: ch2 div 6, drop enable at cnt 1, period completes, then re-enable.
        startTest(4);
        resetPulse();
        setDiv(2, 16'd6);
        nxt_en[2] = 1'b1;
        pc = 32'd1799;
        pt = 32'd32;
        pb = 32'd3903;
        for (int k = 0; k < 12; k++) begin
            if (k == 2) nxt_en[2] = 1'b0;
            if (k == 8) nxt_en[2] = 1'b1;
            stepCh(2, pc[k], pt[k], pb[k]);
        end

        // Test 5: ch0 div 3 and ch1 div 7 realigned by sync; idle channels stay low.
        startTest(5);
        resetPulse();
        setDiv(0, 16'd3);
        setDiv(1, 16'd7);
        nxt_en = 4'b0011;
        clk5 = '{4'd3, 4'd3, 4'd2, 4'd3, 4'd1, 4'd3, 4'd3, 4'd2, 4'd3, 4'd1};
        tck5 = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0};
        for (int k = 0; k < 10; k++) begin
            if (k == 5) nxt_sync = 1'b1;
            applyStimulus(4'hF, clk5[k], tck5[k], 4'b0011);
        end

        // Test 6: all channels running, reset mid-period, then divisors back to 2.
        startTest(6);
        setDiv(2, 16'd4);
        setDiv(3, 16'd5);
        nxt_en = 4'hF;
        applyStimulus(4'hF, 4'b1100, 4'b0001, 4'hF);
        applyStimulus(4'hF, 4'b1101, 4'b0010, 4'hF);
        nxt_rst = 1'b1;
        applyStimulus(4'hF, 4'h0, 4'h0, 4'h0);
        nxt_rst = 1'b0;
        nxt_en  = '0;
        applyStimulus(4'hF, 4'h0, 4'h0, 4'h0);
        applyStimulus(4'hF, 4'h0, 4'h0, 4'h0);
        nxt_en = 4'b0001;
        applyStimulus(4'hF, 4'b0001, 4'b0000, 4'b0001);
        applyStimulus(4'hF, 4'b0000, 4'b0001, 4'b0001);
        applyStimulus(4'hF, 4'b0001, 4'b0000, 4'b0001);
        applyStimulus(4'hF, 4'b0000, 4'b0001, 4'b0001);
        nxt_en = '0;
        applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);

        repeat (3) @(posedge clk_in);
        #2;
        if (sb.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
